// File: rtl/da_param_fir.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : da_param_fir                                                     |
// | Brief   : bit-serial distributed-arithmetic FIR with shift/saturate output |
// |           Optional round-half-up before the output shift: DA_FIR_ROUND_EN  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module da_param_fir #(
  parameter int NB_DATA_IN  = 8,
  parameter int NB_COEFF    = 16,
  parameter int N_TAPS      = 8,
  parameter int NB_DATA_OUT = 28,
  parameter int OUT_SHIFT   = 0,
  parameter logic [N_TAPS*NB_COEFF-1:0] COEFFS =
    {16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd3, 16'd2, 16'd1}
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_data,
  output logic [NB_DATA_OUT-1:0] o_data,
  output logic                   o_valid
);

  localparam int c_cnt_w = (NB_DATA_IN > 1) ? $clog2(NB_DATA_IN) : 1;
  localparam int c_lut_w = NB_COEFF + $clog2(N_TAPS);
  localparam int c_acc_w = NB_DATA_IN + NB_COEFF + $clog2(N_TAPS);
  localparam int c_ext_w = c_acc_w + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NB_DATA_IN - 1);

`ifdef DA_FIR_ROUND_EN
  localparam bit c_round = 1'b1;
`else
  localparam bit c_round = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic                          w_fire;

  logic [c_cnt_w-1:0]            r_cnt;
  logic [NB_DATA_IN-2:0]         r_cap;
  logic [NB_DATA_IN-1:0]         r_taps [N_TAPS];
  logic signed [c_acc_w-1:0]     r_acc;
  logic [NB_DATA_OUT-1:0]        r_data;
  logic                          r_valid;

  logic                          w_last;
  logic [NB_DATA_IN-1:0]         w_sample;
  logic signed [c_lut_w-1:0]     w_lut;
  logic signed [c_acc_w-1:0]     w_lut_ext;
  logic signed [c_acc_w-1:0]     w_term;
  logic signed [c_acc_w-1:0]     w_acc_base;
  logic signed [c_acc_w-1:0]     w_acc_next;
  logic signed [c_ext_w-1:0]     w_ext;
  logic signed [c_ext_w-1:0]     w_rnd;
  logic signed [c_ext_w-1:0]     w_shr;
  logic [NB_DATA_OUT-1:0]        w_out;

  assign w_last   = (r_cnt == c_last);
  assign w_sample = {i_data, r_cap};

  // DA look-up: one address bit per tap, taken from the same bit position of every word
  always_comb begin
    w_lut = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      if (r_taps[k][r_cnt]) begin
        w_lut = w_lut + c_lut_w'($signed(COEFFS[k*NB_COEFF +: NB_COEFF]));
      end
    end
  end

  assign w_lut_ext  = c_acc_w'(w_lut);
  assign w_term     = w_lut_ext <<< r_cnt;
  assign w_acc_base = (r_cnt == '0) ? '0 : r_acc;
  // The MSB of a two's complement word carries negative weight
  assign w_acc_next = w_last ? (w_acc_base - w_term) : (w_acc_base + w_term);

  assign w_ext = c_ext_w'(w_acc_next);

  generate
    if (c_round && (OUT_SHIFT > 0)) begin : g_round
      assign w_rnd = w_ext + (c_ext_w'(1) <<< (OUT_SHIFT - 1));
    end else begin : g_trunc
      assign w_rnd = w_ext;
    end
  endgenerate

  assign w_shr = w_rnd >>> OUT_SHIFT;

  generate
    if (NB_DATA_OUT >= c_ext_w) begin : g_sat_wide
      assign w_out = NB_DATA_OUT'(w_shr);
    end else begin : g_sat_clip
      localparam logic signed [c_ext_w-1:0] c_max =
        {{(c_ext_w-NB_DATA_OUT+1){1'b0}}, {(NB_DATA_OUT-1){1'b1}}};
      localparam logic signed [c_ext_w-1:0] c_min =
        {{(c_ext_w-NB_DATA_OUT+1){1'b1}}, {(NB_DATA_OUT-1){1'b0}}};
      assign w_out = (w_shr > c_max) ? c_max[NB_DATA_OUT-1:0] :
                     (w_shr < c_min) ? c_min[NB_DATA_OUT-1:0] :
                                       w_shr[NB_DATA_OUT-1:0];
    end
  endgenerate

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_FILL;
    end else if (i_enable) begin
      r_state <= w_state_next;
    end
  end

  // FILL waits for the first complete sample; only RUN produces results
  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    case (r_state)
      S_FILL: begin
        if (i_enable && w_last) w_state_next = S_RUN;
      end
      S_RUN: begin
        w_fire = i_enable && w_last;
      end
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
      r_cap <= '0;
      r_acc <= '0;
      for (int k = 0; k < N_TAPS; k++) r_taps[k] <= '0;
    end else if (i_enable) begin
      r_cnt <= w_last ? '0 : (r_cnt + c_cnt_w'(1));
      r_cap <= w_sample[NB_DATA_IN-1:1];
      r_acc <= w_acc_next;
      if (w_last) begin
        r_taps[0] <= w_sample;
        for (int k = 1; k < N_TAPS; k++) r_taps[k] <= r_taps[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_fire;
      if (w_fire) r_data <= w_out;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule
`default_nettype wire
